// File: rtl/sf_pkg.sv
// -----------------------------------------------------------------------------
// sf_pkg
// Shared types and constants for the smoothing-filter UART transmitter.
//   sf_tx_state_t       : transmitter FSM state encoding
//   SF_SAMPLE_W         : width of one filtered sample (two UART bytes)
//   SF_BAUD_DIV_DEFAULT : clocks per UART bit (100 MHz / 115200)
//   sf_even_parity()    : even-parity bit of one byte
// -----------------------------------------------------------------------------
package sf_pkg;

    localparam int SF_SAMPLE_W         = 16;
    localparam int SF_BAUD_DIV_DEFAULT = 868;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } sf_tx_state_t;

    // Even parity: the extra bit makes the total count of ones even.
    function automatic logic sf_even_parity(input logic [7:0] b);
        return ^b;
    endfunction

endpackage : sf_pkg

// File: rtl/sf_tx_fifo.sv
// -----------------------------------------------------------------------------
// sf_tx_fifo
// Synchronous FIFO buffering samples ahead of the UART serialiser.
// First-word fall-through: rdata always shows the oldest stored word, so the
// consumer can latch it on the same edge it pops.
//   clk   : system clock, rising edge
//   rst   : asynchronous, active-low reset (empties the FIFO)
//   push  : write wdata (ignored while full)
//   pop   : discard the oldest word (ignored while empty)
//   wdata : word to store
//   rdata : oldest stored word
//   full  : DEPTH words stored
//   empty : no words stored
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module sf_tx_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    logic do_push;
    logic do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Simultaneous push and pop leave the occupancy unchanged.
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset: contents are meaningless once the pointers clear.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

endmodule : sf_tx_fifo

// File: rtl/sf_uart_tx.sv
// -----------------------------------------------------------------------------
// sf_uart_tx
// Sends filtered samples off-chip over a UART line. Each 16-bit word from the
// valid/ready input is buffered in a FIFO and serialised as two frames, high
// byte first, LSB first within each byte, with no idle gap between frames
// while words are waiting.
//
// Build option: define SF_TX_PARITY_EN for 8E1 frames (11 bits, even parity);
// leave it undefined for 8N1 frames (10 bits).
//
// Ports
//   clk      : system clock, rising edge
//   rst      : asynchronous, active-low reset
//   s_valid  : s_data holds a sample to send
//   s_ready  : a word can be accepted this cycle
//   s_data   : filtered sample
//   tx       : UART line, idle high, registered
//   busy     : frame in progress or FIFO non-empty
//   tx_count : words fully transmitted, wraps modulo 2^32
// -----------------------------------------------------------------------------
module sf_uart_tx
    import sf_pkg::*;
#(
    parameter int CLKS_PER_BIT = SF_BAUD_DIV_DEFAULT,
    parameter int FIFO_DEPTH   = 16,
    parameter int DATA_W       = SF_SAMPLE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              tx,
    output logic              busy,
    output logic [31:0]       tx_count
);

    localparam int                CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  BIT_RELOAD = CNT_W'(CLKS_PER_BIT - 1);

    sf_tx_state_t      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              byte_hi_q, byte_hi_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic              tx_q, tx_d;
    logic [31:0]       tx_count_q, tx_count_d;
    logic              rdy_en_q, rdy_en_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic [DATA_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;

    logic              bit_done;
    logic [7:0]        cur_byte;

    // ------------------------------------------------------------------
    // Input buffer
    // ------------------------------------------------------------------
    sf_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (s_data),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // rdy_en_q holds s_ready low during reset and for no longer than the
    // first edge after release.
    assign rdy_en_d  = 1'b1;
    assign s_ready   = rdy_en_q && !fifo_full;
    assign fifo_push = s_valid && s_ready;

    assign bit_done  = (cnt_q == '0);
    assign cur_byte  = byte_hi_q ? word_q[DATA_W-1 -: 8] : word_q[7:0];

    assign tx        = tx_q;
    assign tx_count  = tx_count_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            byte_hi_q  <= 1'b1;
            word_q     <= '0;
            tx_q       <= 1'b1;
            tx_count_q <= '0;
            rdy_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            byte_hi_q  <= byte_hi_d;
            word_q     <= word_d;
            tx_q       <= tx_d;
            tx_count_q <= tx_count_d;
            rdy_en_q   <= rdy_en_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        byte_hi_d  = byte_hi_q;
        word_d     = word_q;
        tx_count_d = tx_count_q;

        case (state_q)
            IDLE: begin
                if (fifo_pop) begin
                    word_d    = fifo_rdata;
                    byte_hi_d = 1'b1;
                    cnt_d     = BIT_RELOAD;
                    state_d   = START;
                end
            end

            START: begin
                if (bit_done) begin
                    cnt_d     = BIT_RELOAD;
                    bit_idx_d = 3'd0;
                    state_d   = DATA;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            DATA: begin
                if (bit_done) begin
                    cnt_d = BIT_RELOAD;
                    if (bit_idx_q == 3'd7) begin
`ifdef SF_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

`ifdef SF_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    cnt_d   = BIT_RELOAD;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif

            STOP: begin
                if (bit_done) begin
                    cnt_d = BIT_RELOAD;
                    if (byte_hi_q) begin
                        byte_hi_d = 1'b0;
                        state_d   = START;
                    end else begin
                        tx_count_d = tx_count_q + 32'd1;
                        // Chain straight into the next word to avoid an idle gap.
                        if (fifo_pop) begin
                            word_d    = fifo_rdata;
                            byte_hi_d = 1'b1;
                            state_d   = START;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: line level (registered next edge) and FIFO pop strobe
    // ------------------------------------------------------------------
    always_comb begin
        tx_d     = 1'b1;
        fifo_pop = 1'b0;

        case (state_q)
            IDLE: begin
                fifo_pop = !fifo_empty;
            end
            START: begin
                tx_d = 1'b0;
            end
            DATA: begin
                tx_d = cur_byte[bit_idx_q];
            end
`ifdef SF_TX_PARITY_EN
            PARITY: begin
                tx_d = sf_even_parity(cur_byte);
            end
`endif
            STOP: begin
                fifo_pop = bit_done && !byte_hi_q && !fifo_empty;
            end
            default: begin
                tx_d = 1'b1;
            end
        endcase
    end

endmodule : sf_uart_tx

// File: tb/tb_sf_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_sf_uart_tx
// Self-checking bench for sf_uart_tx. A line monitor decodes frames from tx;
// expected bytes are queued when a word is accepted and matched against the
// decoded frames. Build with SF_TX_PARITY_EN defined to cover 8E1 frames.
// -----------------------------------------------------------------------------
module tb_sf_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 16;
`ifdef SF_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int FRAME_CYC = FRAME_BITS * CPB;
    localparam int WORD_CYC  = 2 * FRAME_CYC;

    logic        clk     = 1'b0;
    logic        rst     = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data  = '0;
    logic        s_ready;
    logic        tx;
    logic        busy;
    logic [31:0] tx_count;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int acc_cnt     = 0;
    int first_block = -1;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        int         t0;
    } frame_t;

    frame_t     rx_q[$];
    logic [7:0] exp_q[$];

    sf_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .DATA_W       (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .tx       (tx),
        .busy     (busy),
        .tx_count (tx_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Line monitor: samples each bit at its middle (negedge sampling).
    initial begin : monitor
        frame_t f;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                f.t0  = cyc;
                f.par = 1'b0;
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    f.data[i] = tx;
                end
`ifdef SF_TX_PARITY_EN
                repeat (CPB) @(negedge clk);
                f.par = tx;
`endif
                repeat (CPB) @(negedge clk);
                f.stop = tx;
                rx_q.push_back(f);
            end
        end
    end

    // Expected line level for bit position i of a frame carrying byte b.
    function automatic logic line_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef SF_TX_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic push_word(input logic [15:0] d, input bit hold, output bit ok);
        int guard;
        bit rdy;
        guard   = 0;
        ok      = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        while (!ok && guard < 4000) begin
            @(negedge clk);
            rdy = s_ready;
            if (!rdy && first_block < 0) first_block = acc_cnt;
            @(posedge clk);
            #1;
            if (rdy) ok = 1'b1;
            guard++;
        end
        if (ok) begin
            acc_cnt++;
            exp_q.push_back(d[15:8]);
            exp_q.push_back(d[7:0]);
        end
        if (!hold) s_valid = 1'b0;
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        rst     = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        rx_q.delete();
        exp_q.delete();
        acc_cnt     = 0;
        first_block = -1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (tx !== 1'b1 || busy !== 1'b0 || tx_count !== 32'd0 || s_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold: tx=%b busy=%b tx_count=%0d s_ready=%b, want 1 0 0 0",
                         tx, busy, tx_count, s_ready);
            end
        end
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        vectors++;
        if (s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_ready: s_ready=%b before first edge, want 0", s_ready);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (s_ready !== 1'b1 || tx !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_first_edge: s_ready=%b tx=%b busy=%b, want 1 1 0", s_ready, tx, busy);
        end
        $display("reset: released, s_ready=%b tx=%b", s_ready, tx);
    endtask

    task automatic test_single_word();
        bit         ok;
        logic       want;
        logic [7:0] e;
        frame_t     f;
        do_reset();
        push_word(16'hA55A, 1'b0, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL single_accept: word 0xA55A not accepted, want accepted");
        end
        @(posedge clk);
        #1;
        vectors++;
        if (tx !== 1'b1) begin
            miscompares++;
            $display("FAIL single_latency: tx=%b one edge after accept, want 1", tx);
        end
        for (int j = 0; j < WORD_CYC; j++) begin
            @(posedge clk);
            #1;
            if (j < FRAME_CYC) want = line_bit(8'hA5, j / CPB);
            else               want = line_bit(8'h5A, (j - FRAME_CYC) / CPB);
            vectors++;
            if (tx !== want) begin
                miscompares++;
                $display("FAIL single_bit: cycle %0d tx=%b, want %b", j, tx, want);
            end
        end
        repeat (CPB) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b0 || tx_count !== 32'd1) begin
            miscompares++;
            $display("FAIL single_done: busy=%b tx_count=%0d, want 0 1", busy, tx_count);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (rx_q.size() == 0) begin
                miscompares++;
                $display("FAIL single_rx: no frame received, want byte %02h", e);
            end else begin
                f = rx_q.pop_front();
                if (f.data !== e || f.stop !== 1'b1) begin
                    miscompares++;
                    $display("FAIL single_rx: byte %02h stop %b, want %02h 1", f.data, f.stop, e);
                end
            end
        end
        $display("single: 0xA55A sent, tx_count=%0d", tx_count);
    endtask

    task automatic test_back_to_back();
        bit         ok;
        int         guard;
        int         prev_t0;
        int         n;
        logic [7:0] e;
        frame_t     f;
        do_reset();
        for (int w = 0; w < 20; w++) begin
            push_word(16'(w), (w != 19), ok);
            if (!ok) begin
                vectors++;
                miscompares++;
                $display("FAIL b2b_accept: word %0d timed out, want accepted", w);
                break;
            end
        end
        s_valid = 1'b0;
        vectors++;
        if (first_block != DEPTH + 1) begin
            miscompares++;
            $display("FAIL b2b_full: s_ready first low after %0d accepts, want %0d", first_block, DEPTH + 1);
        end
        guard = 0;
        while (tx_count !== 32'd20 && guard < 20 * WORD_CYC + 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        repeat (2 * CPB) @(posedge clk);
        #1;
        vectors++;
        if (tx_count !== 32'd20 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_count: tx_count=%0d busy=%b, want 20 0", tx_count, busy);
        end
        n = 0;
        prev_t0 = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (rx_q.size() == 0) begin
                miscompares++;
                $display("FAIL b2b_rx: frame %0d missing, want byte %02h", n, e);
            end else begin
                f = rx_q.pop_front();
                if (f.data !== e || f.stop !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_rx: frame %0d byte %02h stop %b, want %02h 1", n, f.data, f.stop, e);
                end
                if (n > 0) begin
                    vectors++;
                    if (f.t0 - prev_t0 != FRAME_CYC) begin
                        miscompares++;
                        $display("FAIL b2b_gap: frame %0d spacing %0d cycles, want %0d", n, f.t0 - prev_t0, FRAME_CYC);
                    end
                end
                prev_t0 = f.t0;
            end
            n++;
        end
        $display("back_to_back: 20 words, tx_count=%0d, first block after %0d", tx_count, first_block);
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int lows;
        do_reset();
        push_word(16'h1234, 1'b0, ok);
        // Third data bit of 0x12 (bit value 0) starts 2 + 3*CPB edges after accept.
        repeat (2 + 3 * CPB) @(posedge clk);
        #2;
        vectors++;
        if (!ok || tx !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_pre: ok=%b tx=%b in data bit 2, want 1 0", ok, tx);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (tx !== 1'b1 || busy !== 1'b0 || tx_count !== 32'd0) begin
            miscompares++;
            $display("FAIL midreset_async: tx=%b busy=%b tx_count=%0d, want 1 0 0", tx, busy, tx_count);
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        lows = 0;
        for (int i = 0; i < 3 * WORD_CYC; i++) begin
            @(posedge clk);
            #1;
            if (tx !== 1'b1) lows++;
        end
        vectors++;
        if (lows != 0 || tx_count !== 32'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_after: low cycles=%0d tx_count=%0d busy=%b, want 0 0 0", lows, tx_count, busy);
        end
        rx_q.delete();
        exp_q.delete();
        $display("reset_midframe: tx idle after release, tx_count=%0d", tx_count);
    endtask

    task automatic test_ignore_invalid();
        do_reset();
        s_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            s_data = 16'($urandom);
            @(posedge clk);
            #1;
            vectors++;
            if (tx !== 1'b1 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL invalid_idle: cycle %0d tx=%b busy=%b, want 1 0", i, tx, busy);
            end
        end
        repeat (FRAME_CYC) @(posedge clk);
        #1;
        vectors++;
        if (tx_count !== 32'd0 || rx_q.size() != 0) begin
            miscompares++;
            $display("FAIL invalid_none: tx_count=%0d frames=%0d, want 0 0", tx_count, rx_q.size());
        end
        $display("ignore_invalid: 50 cycles, tx_count=%0d", tx_count);
    endtask

`ifdef SF_TX_PARITY_EN
    task automatic test_parity();
        bit     ok;
        frame_t f;
        do_reset();
        push_word(16'h0100, 1'b0, ok);
        repeat (WORD_CYC + 4 * CPB) @(posedge clk);
        #1;
        vectors++;
        if (!ok || rx_q.size() != 2) begin
            miscompares++;
            $display("FAIL parity_frames: ok=%b frames=%0d, want 1 2", ok, rx_q.size());
        end else begin
            f = rx_q.pop_front();
            vectors++;
            if (f.data !== 8'h01 || f.par !== 1'b1 || f.stop !== 1'b1) begin
                miscompares++;
                $display("FAIL parity_hi: byte %02h par %b stop %b, want 01 1 1", f.data, f.par, f.stop);
            end
            f = rx_q.pop_front();
            vectors++;
            if (f.data !== 8'h00 || f.par !== 1'b0 || f.stop !== 1'b1) begin
                miscompares++;
                $display("FAIL parity_lo: byte %02h par %b stop %b, want 00 0 1", f.data, f.par, f.stop);
            end
        end
        exp_q.delete();
        $display("parity: 0x0100 sent, tx_count=%0d", tx_count);
    endtask
`endif

    initial begin : main
        test_reset();
        test_single_word();
        test_back_to_back();
        test_reset_midframe();
        test_ignore_invalid();
`ifdef SF_TX_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_sf_uart_tx
